hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU. It is the counterpart of the forwarding unit: forwarding resolves register dependencies that can be bypassed, and this block handles the cases that cannot be bypassed. Those cases are load-use dependencies (one bubble), taken-branch redirects (IF/ID flush) and multi-cycle data-memory accesses (whole-pipeline freeze via a req/ack handshake with timeout). It also keeps saturating stall and flush counters for performance measurement.

## Interface
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before abandoning the access; legal range 2..65535
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- IF_ID_RS_i  in  5  rs of the instruction in ID
- IF_ID_RT_i  in  5  rt of the instruction in ID
- ID_EX_MemRd_i  in  1  instruction in EX is a load
- ID_EX_RT_i  in  5  destination (rt) of the instruction in EX
- Branch_taken_i  in  1  branch in ID resolved taken
- DMem_req_i  in  1  MEM-stage instruction accesses data memory this cycle
- DMem_ack_i  in  1  data memory completes the access this cycle
- PC_Write_o  out  1  1 = PC may update
- IF_ID_Write_o  out  1  1 = IF/ID register may update
- IF_ID_Flush_o  out  1  1 = IF/ID loads a NOP
- ID_EX_Flush_o  out  1  1 = ID/EX loads a bubble (control bits zero)
- Pipe_Freeze_o  out  1  1 = ID/EX, EX/MEM, MEM/WB hold their contents
- Mem_err_o  out  1  sticky memory-timeout flag
- Stall_cnt_o  out  16  cycles with PC_Write_o=0, saturating
- Flush_cnt_o  out  16  cycles with IF_ID_Flush_o=1, saturating

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Internal wait counter wait_cnt is 16 bits; it is cleared on every entry to MEM_WAIT.
- Derived terms:
  - mem_start = DMem_req_i & ~DMem_ack_i. A zero-wait access (req and ack in the same cycle) never stalls.
  - load_use = ID_EX_MemRd_i & (ID_EX_RT_i != 0) & ((ID_EX_RT_i == IF_ID_RS_i) | (ID_EX_RT_i == IF_ID_RT_i)).
- Outputs are combinational from state and inputs (Mealy). Default values: PC_Write_o=1, IF_ID_Write_o=1, all flush and freeze outputs 0.
- RUN state, priority from highest to lowest:
  1. mem_start: PC_Write_o=0, IF_ID_Write_o=0, Pipe_Freeze_o=1; next state MEM_WAIT.
  2. load_use: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1.
  3. Branch_taken_i: IF_ID_Flush_o=1.
- Load-use outranks branch: a branch whose operand is still being loaded stalls, and is re-evaluated in the next cycle.
- MEM_WAIT state, every cycle:
  - Default action: hold. PC_Write_o=0, IF_ID_Write_o=0, Pipe_Freeze_o=1, wait_cnt += 1. load_use and Branch_taken_i are ignored.
  - DMem_ack_i=1: release. Freeze outputs deassert that cycle and the pipeline advances. load_use and branch are evaluated with RUN priorities 2–3. Next state RUN.
  - wait_cnt == MEM_TIMEOUT-1 without ack: release as above, set Mem_err_o=1, next state RUN.
  - A DMem_req_i that stays high in the release cycle does not re-enter MEM_WAIT in that cycle.
- Mem_err_o is cleared only by reset.
- Stall_cnt_o increments on every cycle with PC_Write_o=0. Flush_cnt_o increments on every cycle with IF_ID_Flush_o=1. Both hold at 16'hFFFF.

## Timing
- Reset (rst_i=0 at a clock edge): state RUN, wait_cnt=0, Mem_err_o=0, Stall_cnt_o=0, Flush_cnt_o=0.
- During reset the combinational outputs take their RUN values from the current inputs. Counters do not count while rst_i=0.
- Reset asserted mid-MEM_WAIT: the FSM is in RUN on the next cycle and the pending access is dropped. No error flag is set.
- Load-use costs exactly 1 stall cycle. The instruction in ID re-issues on the following cycle, when the load has moved to MEM and forwarding covers it.
- Memory access with ack on the k-th cycle after req (k≥1) costs exactly k frozen cycles:
  - the req cycle (frozen, RUN), plus k-1 cycles in MEM_WAIT;
  - the ack cycle is not frozen.
- Timeout: exactly MEM_TIMEOUT frozen cycles in total (the req cycle plus MEM_TIMEOUT-1 cycles in MEM_WAIT). The release cycle follows, and Mem_err_o reads 1 from the next cycle onward.
- Branch flush: 1 cycle, with no effect on PC_Write_o.
- Counter outputs are registered and reflect events up to the previous cycle.

## Test plan
- Load-use: ID_EX_MemRd_i=1, ID_EX_RT_i=5, IF_ID_RS_i=5 for one cycle → PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1 for 1 cycle; Stall_cnt_o=1 the next cycle. Repeat with ID_EX_RT_i=0 → no stall.
- Branch vs load-use: Branch_taken_i=1 alone → IF_ID_Flush_o=1, Flush_cnt_o=1. Same stimulus plus load_use → stall only, IF_ID_Flush_o=0.
- Zero-wait memory: DMem_req_i=DMem_ack_i=1 → no freeze, state stays RUN, Stall_cnt_o unchanged.
- Wait states: DMem_req_i=1 held, DMem_ack_i=1 on the 4th cycle → Pipe_Freeze_o=1 for 3 cycles, 0 in the ack cycle; Stall_cnt_o=3; Mem_err_o=0.
- Timeout with MEM_TIMEOUT=4, DMem_req_i=1, no ack → 4 frozen cycles, release on the 5th, Mem_err_o=1 afterwards and sticky. Then assert rst_i=0 for one edge → Mem_err_o=0 and both counters 0.
- Saturation and reset mid-wait: force 65540 stall cycles → Stall_cnt_o=16'hFFFF. Assert reset on the 2nd MEM_WAIT cycle → next cycle state RUN, Pipe_Freeze_o=0 when DMem_req_i=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch flushes and
// data-memory wait-state freezes with timeout, plus stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IF_ID_RS_i,
    input  logic [4:0]  IF_ID_RT_i,
    input  logic        ID_EX_MemRd_i,
    input  logic [4:0]  ID_EX_RT_i,
    input  logic        Branch_taken_i,
    input  logic        DMem_req_i,
    input  logic        DMem_ack_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Flush_o,
    output logic        Pipe_Freeze_o,
    output logic        Mem_err_o,
    output logic [15:0] Stall_cnt_o,
    output logic [15:0] Flush_cnt_o
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    localparam logic [15:0] WaitLast = 16'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] stall_q, flush_q;
    logic        err_q, err_d;

    logic mem_start;
    logic load_use;
    logic advance;

    assign mem_start = DMem_req_i & ~DMem_ack_i;
    assign load_use  = ID_EX_MemRd_i & (ID_EX_RT_i != 5'd0) &
                       ((ID_EX_RT_i == IF_ID_RS_i) |
                        (ID_EX_RT_i == IF_ID_RT_i));

    // While reset is held the outputs behave as in RUN.
    always_comb begin
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        ID_EX_Flush_o = 1'b0;
        Pipe_Freeze_o = 1'b0;
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err_q;
        advance       = 1'b0;

        if (state_q == MEM_WAIT && rst_i) begin
            if (DMem_ack_i || wait_q == WaitLast) begin
                state_d = RUN;
                advance = 1'b1;
                if (!DMem_ack_i) begin
                    err_d = 1'b1;
                end
            end else begin
                PC_Write_o    = 1'b0;
                IF_ID_Write_o = 1'b0;
                Pipe_Freeze_o = 1'b1;
                wait_d        = wait_q + 16'd1;
            end
        end else if (mem_start) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Pipe_Freeze_o = 1'b1;
            state_d       = MEM_WAIT;
            wait_d        = 16'd0;
        end else begin
            advance = 1'b1;
        end

        if (advance) begin
            if (load_use) begin
                PC_Write_o    = 1'b0;
                IF_ID_Write_o = 1'b0;
                ID_EX_Flush_o = 1'b1;
            end else if (Branch_taken_i) begin
                IF_ID_Flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= 16'd0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (!PC_Write_o && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (IF_ID_Flush_o && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign Mem_err_o   = err_q;
    assign Stall_cnt_o = stall_q;
    assign Flush_cnt_o = flush_q;

endmodule
